core_column_readout_ctrl: RTL and testbench

Sequences readout of one core column of pixel regions that are daisy-chained by token. The block accepts a trigger-ID read request and broadcasts that trigger ID to all regions. It then injects the token at the chain head and issues single-cycle Read strobes while the chain tail reports remaining data. Each captured 16-bit ToT word is forwarded on a valid/ready output, and every event is closed with an end-of-event marker word.

---
 rtl/core_column_readout_ctrl.sv | 127 ++++++++++++
 tb/tb_core_column_readout_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_column_readout_ctrl.sv
// Core column readout sequencer: broadcasts a trigger ID, walks the region token chain, forwards ToT words plus an EOE marker.
// Latency: first Read TOK_SETTLE+2 cycles after request acceptance; empty-event marker valid TOK_SETTLE+3 cycles after acceptance.
// Backpressure: a word is held on the output until OutReady; no new Read is issued while the output slot is occupied.
module core_column_readout_ctrl #(
    parameter int TRIG_ID_W  = 5,
    parameter int TOK_SETTLE = 2,
    parameter int MAX_WORDS  = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 ReqValid,
    input  logic [TRIG_ID_W-1:0] ReqTrigId,
    output logic                 ReqReady,
    output logic [TRIG_ID_W-1:0] TrigIdReq,
    output logic                 TokIn,
    input  logic                 TokOut,
    output logic                 Read,
    input  logic [15:0]          DataIn,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [15:0]          OutData,
    output logic [TRIG_ID_W-1:0] OutTrigId,
    output logic                 OutEoe,
    output logic                 OutTrunc
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int SET_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CHECK,
        READ,
        GAP,
        EOE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [SET_W-1:0]   settle;
    logic               trunc;
    logic               slot_free;

    assign slot_free = !OutValid || OutReady;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            count     <= '0;
            settle    <= '0;
            trunc     <= 1'b0;
            ReqReady  <= 1'b1;
            TrigIdReq <= '0;
            TokIn     <= 1'b0;
            Read      <= 1'b0;
            OutValid  <= 1'b0;
            OutData   <= '0;
            OutTrigId <= '0;
            OutEoe    <= 1'b0;
            OutTrunc  <= 1'b0;
        end else begin
            // A handshake frees the slot; a load later in this block may refill it in the same cycle.
            if (OutValid && OutReady) begin
                OutValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        TrigIdReq <= ReqTrigId;
                        OutTrigId <= ReqTrigId;
                        count     <= '0;
                        trunc     <= 1'b0;
                        settle    <= SET_W'(TOK_SETTLE);
                        ReqReady  <= 1'b0;
                        TokIn     <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP, GAP: begin
                    if (settle == SET_W'(1)) begin
                        state <= CHECK;
                    end else begin
                        settle <= settle - SET_W'(1);
                    end
                end
                CHECK: begin
                    if (TokOut) begin
                        state <= EOE;
                    end else if (count == CNT_W'(MAX_WORDS)) begin
                        trunc <= 1'b1;
                        state <= EOE;
                    end else if (slot_free) begin
                        Read  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    Read     <= 1'b0;
                    OutData  <= DataIn;
                    OutEoe   <= 1'b0;
                    OutTrunc <= 1'b0;
                    OutValid <= 1'b1;
                    count    <= count + CNT_W'(1);
                    settle   <= SET_W'(TOK_SETTLE);
                    state    <= GAP;
                end
                EOE: begin
                    if (slot_free) begin
                        OutData  <= {{(16-CNT_W){1'b0}}, count};
                        OutEoe   <= 1'b1;
                        OutTrunc <= trunc;
                        OutValid <= 1'b1;
                        TokIn    <= 1'b0;
                        ReqReady <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_column_readout_ctrl.sv
// Bench for core_column_readout_ctrl: directed scenarios plus random events against a word-list reference model.
// Region chain is modelled as per-trigger word lists; expected output is the first min(N, MAX_WORDS) words plus a marker.
module tb_core_column_readout_ctrl;

    localparam int TRIG_ID_W  = 5;
    localparam int TOK_SETTLE = 2;
    localparam int MAX_WORDS  = 32;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 ReqValid = 1'b0;
    logic [TRIG_ID_W-1:0] ReqTrigId = '0;
    logic                 ReqReady;
    logic [TRIG_ID_W-1:0] TrigIdReq;
    logic                 TokIn;
    logic                 TokOut = 1'b1;
    logic                 Read;
    logic [15:0]          DataIn = '0;
    logic                 OutValid;
    logic                 OutReady = 1'b1;
    logic [15:0]          OutData;
    logic [TRIG_ID_W-1:0] OutTrigId;
    logic                 OutEoe;
    logic                 OutTrunc;

    always #5 Clk = ~Clk;

    core_column_readout_ctrl #(
        .TRIG_ID_W (TRIG_ID_W),
        .TOK_SETTLE(TOK_SETTLE),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqTrigId(ReqTrigId),
        .ReqReady (ReqReady),
        .TrigIdReq(TrigIdReq),
        .TokIn    (TokIn),
        .TokOut   (TokOut),
        .Read     (Read),
        .DataIn   (DataIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutTrigId(OutTrigId),
        .OutEoe   (OutEoe),
        .OutTrunc (OutTrunc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0]          d;
        logic                 eoe;
        logic                 tr;
        logic [TRIG_ID_W-1:0] tid;
    } exp_t;

    exp_t exp_q[$];
    int   exp_reads[$];

    // Per-trigger pending data held by the region chain
    logic [15:0] mem_dat [32][64];
    int          mem_len [32];
    int          mem_rd  [32];

    int ready_mode = 0;   // 0: always ready, 1: random, 2: stall 10 cycles after first word
    int cyc = 0, busy = 0, acc_cyc = 0, reads_evt = 0, last_read = 0;
    int evt_mode = 0, evt_n = 0, stall_left = 0, acc_cnt = 0;
    logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_read = 1'b0;
    logic [17:0] prev_out = '0;

    task automatic load_event(input int id, input int n);
        mem_len[id] = n;
        mem_rd[id]  = 0;
        for (int i = 0; i < n; i++) mem_dat[id][i] = 16'($urandom);
    endtask

    // Monitor, scoreboard and region-chain responder, all evaluated mid-cycle
    initial begin
        logic new_load, hs;
        int   n, k, id;
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                exp_q.delete();
                exp_reads.delete();
                busy = 0; reads_evt = 0; stall_left = 0;
                prev_valid = 1'b0; prev_hs = 1'b0; prev_read = 1'b0;
            end else begin
                cyc++;
                new_load = OutValid && (!prev_valid || prev_hs);
                if (new_load && OutEoe) begin
                    busy = 0;
                    if (exp_reads.size() > 0) check_eq("read_count", reads_evt, exp_reads.pop_front());
                    else check_eq("marker_expected", exp_reads.size(), 1);
                    if (evt_mode == 0 && evt_n == 0) check_eq("empty_marker_time", cyc - acc_cyc, TOK_SETTLE + 3);
                end
                check_eq("tok_in", TokIn, busy != 0);
                check_eq("req_ready", ReqReady, busy == 0);
                if (prev_valid && !prev_hs) begin
                    check_eq("hold_valid", OutValid, 1);
                    check_eq("hold_data", {OutData, OutEoe, OutTrunc}, prev_out);
                end
                id = int'(TrigIdReq);
                if (Read) begin
                    check_eq("read_busy", busy, 1);
                    check_eq("read_pulse", prev_read, 0);
                    check_eq("read_slot_free", !prev_valid || prev_hs, 1);
                    if (evt_mode == 0) begin
                        if (reads_evt == 0) check_eq("first_read_time", cyc - acc_cyc, TOK_SETTLE + 2);
                        else check_eq("read_spacing", cyc - last_read, TOK_SETTLE + 2);
                    end
                    reads_evt++;
                    last_read = cyc;
                    if (mem_rd[id] < mem_len[id]) begin
                        DataIn = mem_dat[id][mem_rd[id]];
                        mem_rd[id]++;
                    end else begin
                        DataIn = 16'($urandom);
                    end
                end else begin
                    DataIn = 16'($urandom);
                end
                TokOut = (mem_rd[id] >= mem_len[id]);

                if (ReqValid && ReqReady) begin
                    id = int'(ReqTrigId);
                    n  = mem_len[id];
                    k  = (n > MAX_WORDS) ? MAX_WORDS : n;
                    for (int i = 0; i < k; i++) exp_q.push_back({mem_dat[id][i], 1'b0, 1'b0, ReqTrigId});
                    exp_q.push_back({16'(k), 1'b1, n > MAX_WORDS, ReqTrigId});
                    exp_reads.push_back(k);
                    acc_cyc = cyc; reads_evt = 0; evt_mode = ready_mode; evt_n = n;
                    busy = 1; acc_cnt++;
                end

                if (ready_mode == 2 && new_load && !OutEoe && reads_evt == 1) stall_left = 10;
                if (ready_mode == 1) OutReady = ($urandom_range(0, 3) != 0);
                else OutReady = (stall_left == 0);
                if (stall_left > 0) stall_left--;

                hs = OutValid && OutReady;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_word", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.eoe) check_eq("marker", {OutData, OutEoe, OutTrunc}, {e.d, e.eoe, e.tr});
                        else check_eq("data_word", {OutData, OutEoe, OutTrigId}, {e.d, e.eoe, e.tid});
                    end
                end
                prev_valid = OutValid;
                prev_hs    = hs;
                prev_read  = Read;
                prev_out   = {OutData, OutEoe, OutTrunc};
            end
        end
    end

    task automatic wait_acc(input int budget);
        int start;
        logic ok;
        start = acc_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge Clk);
            #1;
            if (acc_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("accept_timeout", ok, 1);
    endtask

    task automatic request(input int id);
        ReqTrigId = TRIG_ID_W'(id);
        ReqValid  = 1'b1;
        wait_acc(100);
        ReqValid  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge Clk);
            #1;
            if (busy == 0 && exp_q.size() == 0 && !OutValid) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("done_timeout", done, 1);
    endtask

    initial begin
        int id, n;
        for (int i = 0; i < 32; i++) begin
            mem_len[i] = 0;
            mem_rd[i]  = 0;
        end
        #2 Reset = 1'b0;
        #1 check_eq("reset_state", {ReqReady, TokIn, Read, OutValid, OutEoe, OutTrunc, OutData, OutTrigId, TrigIdReq},
                    {1'b1, 31'd0});
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;

        // Three-word event with known data
        mem_dat[9][0] = 16'h1234;
        mem_dat[9][1] = 16'h00F0;
        mem_dat[9][2] = 16'hABCD;
        mem_len[9] = 3;
        mem_rd[9]  = 0;
        request(9);
        wait_done(200);
        check_eq("idle_after_event", {TokIn, ReqReady, TrigIdReq}, {1'b0, 1'b1, 5'd9});

        // Empty event
        load_event(1, 0);
        request(1);
        wait_done(200);

        // Truncation at MAX_WORDS
        load_event(20, 40);
        request(20);
        wait_done(1000);
        check_eq("trunc_no_extra_read", mem_rd[20], MAX_WORDS);

        // Output stall after the first word
        ready_mode = 2;
        load_event(5, 3);
        request(5);
        wait_done(300);
        ready_mode = 0;

        // Reset during the gap after the second read
        load_event(7, 3);
        request(7);
        for (int i = 0; i < 100 && reads_evt < 2; i++) begin
            @(posedge Clk);
            #1;
        end
        check_eq("reached_second_read", reads_evt, 2);
        #2 Reset = 1'b0;
        #1 check_eq("reset_mid_event", {ReqReady, TokIn, Read, OutValid, OutEoe, OutTrunc, OutData},
                    {1'b1, 21'd0});
        @(negedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b1;
        load_event(12, 2);
        request(12);
        wait_done(300);

        // Back-to-back requests with ReqValid held
        load_event(3, 2);
        load_event(4, 1);
        ReqTrigId = 5'd3;
        ReqValid  = 1'b1;
        wait_acc(100);
        ReqTrigId = 5'd4;
        wait_acc(300);
        ReqValid  = 1'b0;
        wait_done(300);

        // Random events
        for (int r = 0; r < 14; r++) begin
            ready_mode = $urandom_range(0, 1);
            id = $urandom_range(0, 31);
            n  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            load_event(id, n);
            request(id);
            wait_done(3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
